// File: rtl/stage_mem.sv
// MEM stage: drives data-bus loads/stores over a req/ack handshake and
// returns the write-back bundle, stalling the pipeline until the bus completes.
module stage_mem #(
  parameter int BUS_TIMEOUT = 16,
  parameter int TIMER_WIDTH = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  stall,
  input  logic        ex_reg_write_enable,
  input  logic [4:0]  ex_reg_write_address,
  input  logic [31:0] ex_reg_write_data,
  input  logic [3:0]  ex_mem_op,
  input  logic [31:0] ex_mem_address,
  input  logic [31:0] ex_mem_store_data,
  output logic        bus_request,
  output logic        bus_write_enable,
  output logic [31:0] bus_address,
  output logic [3:0]  bus_byte_select,
  output logic [31:0] bus_write_data,
  input  logic [31:0] bus_read_data,
  input  logic        bus_ack,
  output logic        stall_request,
  output logic        mem_reg_write_enable,
  output logic [4:0]  mem_reg_write_address,
  output logic [31:0] mem_reg_write_data,
  output logic        mem_misaligned,
  output logic        bus_error
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST =
    TIMER_WIDTH'(BUS_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic [31:0]            data_q, data_d;
  logic                   err_q, err_d;
  logic                   bus_error_q, bus_error_d;

  logic [1:0]  a;
  logic        is_load, is_store, is_byte, is_half, is_word;
  logic        misaligned, mem_go;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] load_val;
  logic [3:0]  mask;
  logic [31:0] wdata;

  logic        req_c, stall_c, en_c, mis_c;
  logic [31:0] wb_data_c;

  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[3:0]};

  assign a = ex_mem_address[1:0];

  always_comb begin
    is_load  = ex_mem_op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    is_store = ex_mem_op inside {OP_SB, OP_SH, OP_SW};
    is_byte  = ex_mem_op inside {OP_LB, OP_LBU, OP_SB};
    is_half  = ex_mem_op inside {OP_LH, OP_LHU, OP_SH};
    is_word  = ex_mem_op inside {OP_LW, OP_SW};
    misaligned = (is_half & a[0]) | (is_word & (a != 2'd0));
    mem_go     = (is_load | is_store) & ~misaligned;
  end

  // Big-endian: address offset 0 lives in the most significant lane.
  always_comb begin
    lb = bus_read_data[7:0];
    unique case (a)
      2'd0: lb = bus_read_data[31:24];
      2'd1: lb = bus_read_data[23:16];
      2'd2: lb = bus_read_data[15:8];
      2'd3: lb = bus_read_data[7:0];
      default: lb = bus_read_data[7:0];
    endcase
    lh = a[1] ? bus_read_data[15:0] : bus_read_data[31:16];
    load_val = bus_read_data;
    unique case (ex_mem_op)
      OP_LB:   load_val = {{24{lb[7]}}, lb};
      OP_LBU:  load_val = {24'd0, lb};
      OP_LH:   load_val = {{16{lh[15]}}, lh};
      OP_LHU:  load_val = {16'd0, lh};
      default: load_val = bus_read_data;
    endcase
  end

  always_comb begin
    mask  = 4'b1111;
    wdata = ex_mem_store_data;
    if (is_byte) begin
      mask  = 4'b1000 >> a;
      wdata = {4{ex_mem_store_data[7:0]}};
    end else if (is_half) begin
      mask  = a[1] ? 4'b0011 : 4'b1100;
      wdata = {2{ex_mem_store_data[15:0]}};
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    data_d      = data_q;
    err_d       = err_q;
    bus_error_d = 1'b0;
    req_c       = 1'b0;
    stall_c     = 1'b0;
    en_c        = 1'b0;
    mis_c       = 1'b0;
    wb_data_c   = ex_reg_write_data;
    unique case (state_q)
      IDLE: begin
        mis_c = misaligned;
        if (mem_go) begin
          req_c   = 1'b1;
          stall_c = 1'b1;
          timer_d = '0;
          if (bus_ack) begin
            data_d  = load_val;
            err_d   = 1'b0;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end else begin
          en_c = ex_reg_write_enable & ~misaligned & ~is_load & ~is_store;
        end
      end
      WAIT: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        timer_d = timer_q + 1'b1;
        if (bus_ack) begin
          data_d  = load_val;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (timer_q == TIMER_LAST) begin
          err_d       = 1'b1;
          bus_error_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        en_c      = is_load & ex_reg_write_enable & ~err_q;
        wb_data_c = data_q;
        if (!stall[4]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      data_q      <= data_d;
      err_q       <= err_d;
      bus_error_q <= bus_error_d;
    end
  end

  // Everything is forced low while reset is held, including pass-through paths.
  logic act;
  assign act = reset & req_c;

  assign bus_request      = act;
  assign bus_write_enable = act & is_store;
  assign bus_address      = act ? {ex_mem_address[31:2], 2'b00} : '0;
  assign bus_byte_select  = act ? mask : '0;
  assign bus_write_data   = (act & is_store) ? wdata : '0;
  assign stall_request    = reset & stall_c;

  assign mem_reg_write_enable  = reset & en_c;
  assign mem_reg_write_address = reset ? ex_reg_write_address : '0;
  assign mem_reg_write_data    = reset ? wb_data_c : '0;
  assign mem_misaligned        = reset & mis_c;
  assign bus_error             = reset & bus_error_q;

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem with a write-back scoreboard queue.
// Stimulus is driven just after the falling edge; outputs sampled 1 ns later.
module tb_stage_mem;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  stall = '0;
  logic        ex_reg_write_enable = 1'b0;
  logic [4:0]  ex_reg_write_address = '0;
  logic [31:0] ex_reg_write_data = '0;
  logic [3:0]  ex_mem_op = '0;
  logic [31:0] ex_mem_address = '0;
  logic [31:0] ex_mem_store_data = '0;
  logic        bus_request;
  logic        bus_write_enable;
  logic [31:0] bus_address;
  logic [3:0]  bus_byte_select;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data = '0;
  logic        bus_ack = 1'b0;
  logic        stall_request;
  logic        mem_reg_write_enable;
  logic [4:0]  mem_reg_write_address;
  logic [31:0] mem_reg_write_data;
  logic        mem_misaligned;
  logic        bus_error;

  stage_mem #(.BUS_TIMEOUT(16), .TIMER_WIDTH(5)) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .ex_reg_write_enable(ex_reg_write_enable),
    .ex_reg_write_address(ex_reg_write_address),
    .ex_reg_write_data(ex_reg_write_data),
    .ex_mem_op(ex_mem_op),
    .ex_mem_address(ex_mem_address),
    .ex_mem_store_data(ex_mem_store_data),
    .bus_request(bus_request),
    .bus_write_enable(bus_write_enable),
    .bus_address(bus_address),
    .bus_byte_select(bus_byte_select),
    .bus_write_data(bus_write_data),
    .bus_read_data(bus_read_data),
    .bus_ack(bus_ack),
    .stall_request(stall_request),
    .mem_reg_write_enable(mem_reg_write_enable),
    .mem_reg_write_address(mem_reg_write_address),
    .mem_reg_write_data(mem_reg_write_data),
    .mem_misaligned(mem_misaligned),
    .bus_error(bus_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  wb_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] sd, input logic wen,
                       input logic [4:0] wa, input logic [31:0] alu,
                       input logic [31:0] rd);
    ex_mem_op            = op;
    ex_mem_address       = addr;
    ex_mem_store_data    = sd;
    ex_reg_write_enable  = wen;
    ex_reg_write_address = wa;
    ex_reg_write_data    = alu;
    bus_read_data        = rd;
  endtask

  task automatic push(input logic en, input logic [4:0] wa,
                      input logic [31:0] d);
    wb_t e;
    e.en = en;
    e.addr = wa;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    wb_t e;
    chk({tag, "_sb_depth"}, sb.size(), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
    end else begin
      e.en = 1'b1;
      e.addr = 5'h1f;
      e.data = 32'hdead_dead;
    end
    chk({tag, "_wb_en"}, mem_reg_write_enable, e.en);
    chk({tag, "_wb_addr"}, mem_reg_write_address, e.addr);
    if (e.en) chk({tag, "_wb_data"}, mem_reg_write_data, e.data);
  endtask

  // ack_at: cycle index of the ack (0 = issue cycle), negative = never.
  task automatic access(input string tag, input int ack_at,
                        input logic [3:0] exp_mask,
                        input logic [31:0] exp_addr,
                        input logic exp_we, input logic [31:0] exp_wd,
                        input int exp_stalls);
    int cyc;
    cyc = 0;
    bus_ack = (ack_at == 0);
    #1;
    chk({tag, "_req"}, bus_request, 1);
    chk({tag, "_mask"}, bus_byte_select, exp_mask);
    chk({tag, "_baddr"}, bus_address, exp_addr);
    chk({tag, "_we"}, bus_write_enable, exp_we);
    if (exp_we) chk({tag, "_wdata"}, bus_write_data, exp_wd);
    while (stall_request === 1'b1 && cyc < 40) begin
      @(negedge clock);
      cyc++;
      bus_ack = (cyc == ack_at);
      #1;
    end
    bus_ack = 1'b0;
    chk({tag, "_stalls"}, cyc, exp_stalls);
    chk({tag, "_done_req"}, bus_request, 0);
  endtask

  initial begin
    // Outputs held low during reset, even with a live LW on ex_*
    drive(4'd5, 32'h100, 32'h0, 1'b1, 5'd4, 32'h55, 32'h0);
    #3;
    chk("rst_req", bus_request, 0);
    chk("rst_stall", stall_request, 0);
    chk("rst_wb_en", mem_reg_write_enable, 0);
    chk("rst_wb_data", mem_reg_write_data, 0);
    chk("rst_buserr", bus_error, 0);
    drive(4'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0);
    @(negedge clock);
    reset = 1'b1;

    // NONE pass-through
    @(negedge clock);
    drive(4'd0, 32'h40, 32'h0, 1'b1, 5'd3, 32'h1234_5678, 32'h0);
    push(1'b1, 5'd3, 32'h1234_5678);
    #1;
    chk("none_req", bus_request, 0);
    chk("none_stall", stall_request, 0);
    pop_chk("none");

    // Reserved op 12 behaves as NONE
    @(negedge clock);
    drive(4'd12, 32'h0, 32'h0, 1'b1, 5'd5, 32'hCAFE_F00D, 32'h0);
    push(1'b1, 5'd5, 32'hCAFE_F00D);
    #1;
    chk("op12_req", bus_request, 0);
    pop_chk("op12");

    // Reset in the middle of a waiting LW
    @(negedge clock);
    drive(4'd5, 32'h100, 32'h0, 1'b1, 5'd6, 32'h0, 32'h0);
    #1;
    chk("rmid_req_idle", bus_request, 1);
    @(negedge clock);
    #1;
    chk("rmid_req_wait", bus_request, 1);
    chk("rmid_stall_wait", stall_request, 1);
    reset = 1'b0;
    #1;
    chk("rmid_req_drop", bus_request, 0);
    chk("rmid_stall_drop", stall_request, 0);
    drive(4'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'hFFFF_FFFF);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    bus_ack = 1'b1;
    #1;
    chk("rmid_late_ack_en", mem_reg_write_enable, 0);
    chk("rmid_late_ack_data", mem_reg_write_data, 0);
    @(negedge clock);
    bus_ack = 1'b0;
    #1;
    chk("rmid_after_req", bus_request, 0);
    chk("rmid_after_data", mem_reg_write_data, 0);
    chk("rmid_after_err", bus_error, 0);

    // Zero-wait LB, sign-extended low lane
    @(negedge clock);
    drive(4'd1, 32'h1003, 32'h0, 1'b1, 5'd7, 32'h0, 32'h0000_00F0);
    push(1'b1, 5'd7, 32'hFFFF_FFF0);
    access("lb", 0, 4'b0001, 32'h1000, 1'b0, 32'h0, 1);
    pop_chk("lb");

    // LHU, ack on third WAIT cycle
    @(negedge clock);
    drive(4'd4, 32'h2000, 32'h0, 1'b1, 5'd9, 32'h0, 32'h8001_1234);
    push(1'b1, 5'd9, 32'h0000_8001);
    access("lhu", 3, 4'b1100, 32'h2000, 1'b0, 32'h0, 4);
    pop_chk("lhu");

    // SH lane steering
    @(negedge clock);
    drive(4'd7, 32'h0002, 32'hAAAA_5678, 1'b1, 5'd10, 32'h0, 32'h0);
    push(1'b0, 5'd10, 32'h0);
    access("sh", 1, 4'b0011, 32'h0, 1'b1, 32'h5678_5678, 2);
    pop_chk("sh");

    // LH sign-extended low half
    @(negedge clock);
    drive(4'd3, 32'h0002, 32'h0, 1'b1, 5'd11, 32'h0, 32'h1234_8765);
    push(1'b1, 5'd11, 32'hFFFF_8765);
    access("lh", 0, 4'b0011, 32'h0, 1'b0, 32'h0, 1);
    pop_chk("lh");

    // LW after two waits
    @(negedge clock);
    drive(4'd5, 32'h0010, 32'h0, 1'b1, 5'd12, 32'h0, 32'hDEAD_BEEF);
    push(1'b1, 5'd12, 32'hDEAD_BEEF);
    access("lw", 2, 4'b1111, 32'h10, 1'b0, 32'h0, 3);
    pop_chk("lw");

    // LBU top lane
    @(negedge clock);
    drive(4'd2, 32'h0004, 32'h0, 1'b1, 5'd13, 32'h0, 32'h9A00_0000);
    push(1'b1, 5'd13, 32'h0000_009A);
    access("lbu", 0, 4'b1000, 32'h4, 1'b0, 32'h0, 1);
    pop_chk("lbu");

    // SB replication
    @(negedge clock);
    drive(4'd6, 32'h0005, 32'h1122_3344, 1'b1, 5'd14, 32'h0, 32'h0);
    push(1'b0, 5'd14, 32'h0);
    access("sb", 0, 4'b0100, 32'h4, 1'b1, 32'h4444_4444, 1);
    pop_chk("sb");

    // Misaligned LW and SH
    @(negedge clock);
    drive(4'd5, 32'h0006, 32'h0, 1'b1, 5'd15, 32'h0, 32'h0);
    push(1'b0, 5'd15, 32'h0);
    #1;
    chk("mis_lw_flag", mem_misaligned, 1);
    chk("mis_lw_req", bus_request, 0);
    chk("mis_lw_stall", stall_request, 0);
    pop_chk("mis_lw");
    @(negedge clock);
    drive(4'd7, 32'h0001, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0);
    #1;
    chk("mis_sh_flag", mem_misaligned, 1);
    chk("mis_sh_req", bus_request, 0);

    // SW timeout, then hold DONE with stall[4]
    @(negedge clock);
    drive(4'd8, 32'h0008, 32'hCAFE_BABE, 1'b0, 5'd16, 32'h0, 32'h0);
    push(1'b0, 5'd16, 32'h0);
    access("to", -1, 4'b1111, 32'h8, 1'b1, 32'hCAFE_BABE, 17);
    chk("to_buserr", bus_error, 1);
    pop_chk("to");
    stall[4] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      #1;
      chk("to_hold_req", bus_request, 0);
      chk("to_hold_stall", stall_request, 0);
      chk("to_hold_buserr", bus_error, 0);
    end
    stall[4] = 1'b0;
    @(negedge clock);
    #1;
    chk("to_release_reissue", bus_request, 1);
    drive(4'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0);
    #1;
    chk("to_final_req", bus_request, 0);
    chk("to_final_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stage_mem.md
Name: stage_mem

Overview:
- MEM stage of the five-stage MIPS pipeline: consumes EX/MEM register outputs, performs data-bus loads/stores, produces mem_reg_write_* consumed by trans_mem_wb.
- Multi-cycle bus access via req/ack handshake; asserts stall_request to the pipeline controller until the access completes.
- Handles byte/half/word lane steering (big-endian), load sign/zero extension, misalignment detection and bus timeout.

Parameters:
- BUS_TIMEOUT, 16, max cycles in WAIT before abort with bus_error; must be >= 1.
- TIMER_WIDTH, 5, counter width; must be able to hold BUS_TIMEOUT.

Ports:
- clock  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- stall  in  6  controller stall vector; stall[4] = MEM/WB hold
- ex_reg_write_enable  in  1  GPR write enable from EX/MEM
- ex_reg_write_address  in  5  destination GPR
- ex_reg_write_data  in  32  ALU result, used for non-load ops
- ex_mem_op  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE
- ex_mem_address  in  32  effective address
- ex_mem_store_data  in  32  rt value for stores
- bus_request  out  1  access valid
- bus_write_enable  out  1  1 = store
- bus_address  out  32  word address, low 2 bits forced to 0
- bus_byte_select  out  4  lane mask; bit3 = data[31:24]
- bus_write_data  out  32  store data replicated into lanes
- bus_read_data  in  32  read data, valid with bus_ack
- bus_ack  in  1  one-cycle completion strobe
- stall_request  out  1  hold the pipeline
- mem_reg_write_enable  out  1  to trans_mem_wb
- mem_reg_write_address  out  5
- mem_reg_write_data  out  32
- mem_misaligned  out  1  alignment exception flag
- bus_error  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (reset=0, async): state IDLE, timer 0, captured data 0, bus_error 0. All outputs 0 while reset is low. A reset mid-access drops bus_request immediately. A late bus_ack is ignored.
- Lanes (big-endian): byte at addr[1:0]=0 uses lane 3 (mask 1000). Half at addr[1]=0 uses mask 1100; otherwise 0011. Word uses mask 1111. SB replicates rt[7:0] ×4. SH replicates rt[15:0] ×2. SW passes rt unchanged.
- Misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0. For that op: no bus request, mem_misaligned=1 combinationally, mem_reg_write_enable=0, no stall.
- NONE op: outputs pass through combinationally from ex_*; no stall; bus_request=0.
- FSM states IDLE, WAIT, DONE:
  - IDLE, aligned memory op: bus_request=1 and stall_request=1 combinationally. Next state WAIT with timer cleared. If bus_ack arrives the same cycle, capture data and go to DONE.
  - WAIT: bus_request=1, stall_request=1, timer increments each cycle.
    - bus_ack: capture the extracted load data; go to DONE.
    - Timer reaches BUS_TIMEOUT-1 with no ack: bus_error pulses next cycle, reg write is suppressed, go to DONE.
    - Ack and timeout in the same cycle: ack wins.
  - DONE: bus_request=0, stall_request=0. Loads drive mem_reg_write_data from the captured register. Stores force mem_reg_write_enable=0.
    - Leave to IDLE when stall[4]=0; remain in DONE while stall[4]=1.
- Bus outputs stay stable for the whole request: address, mask and data are sourced from ex_* inputs, which the controller holds during stall_request.
- Load extraction: LB/LH sign-extend; LBU/LHU zero-extend; LW takes the word unchanged.
- Write enable for a completed load equals ex_reg_write_enable; data = extracted value; address = ex_reg_write_address.
- Latency: a non-memory op takes 0 extra cycles. A memory op takes (cycles to ack + 1); a zero-wait ack costs 1 stall cycle.

Test Plan:
- Reset mid-WAIT: LW issued, pull reset low before ack -> bus_request=0 immediately, state IDLE. An ack after reset release is ignored; outputs stay 0.
- Zero-wait LB: LB addr 0x1003, bus_read_data 0x000000F0 with ack in the same cycle -> byte_select 0001. One stall cycle, then mem_reg_write_data=0xFFFFFFF0, enable=1.
- Waited LHU: LHU addr 0x2000, ack on 3rd WAIT cycle with data 0x8001_1234 -> byte_select 1100. stall_request high 4 cycles; result 0x00008001.
- Store steering: SH addr 0x0002, rt=0xAAAA5678 -> bus_write_enable=1, mask 0011, bus_write_data 0x56785678, bus_address 0x0000. In DONE, mem_reg_write_enable=0.
- Misaligned LW: LW addr 0x0006 -> mem_misaligned=1, bus_request=0, stall_request=0, no reg write.
- Timeout: SW with no ack, BUS_TIMEOUT=16 -> 16 WAIT cycles, bus_error pulses once, then DONE. With stall[4]=1 held 2 extra cycles, the block stays in DONE until stall[4]=0.
